// File: rtl/traceback_unit_pkg.sv
// rtl/traceback_unit_pkg.sv - shared trellis sizes, FSM encoding and state-step helper for the traceback unit
package traceback_unit_pkg;

  // K=7 trellis: 64 states, each named by the six most recent input bits
  localparam int unsigned NUM_STATES   = 64;
  localparam int unsigned STATE_W      = 6;
  localparam int unsigned TB_DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACE = 2'd1,
    ST_EMIT  = 2'd2
  } tb_fsm_e;

  // Bit 0 of a state is its newest input bit; stepping back shifts the
  // stored decision in as the oldest bit.
  function automatic logic [STATE_W-1:0] prev_state(input logic [STATE_W-1:0] s,
                                                     input logic               d);
    return {d, s[STATE_W-1:1]};
  endfunction

endpackage

// File: rtl/traceback_unit_survivor_ram.sv
// rtl/traceback_unit_survivor_ram.sv - survivor decision store, one sync write port and one async read port
module tb_survivor_ram
  import traceback_unit_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 128,
  parameter int unsigned ADDR_W    = 7
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [NUM_STATES-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [NUM_STATES-1:0] rdata_o
);

  // Contents are deliberately not reset; every traced entry is written before it is read.
  logic [NUM_STATES-1:0] mem_q [MEM_DEPTH];

  // Store one trellis step of decisions per accepted input
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read in the same cycle so a traceback step needs no extra latency
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/traceback_unit.sv
// rtl/traceback_unit.sv - Viterbi survivor traceback: stores decisions, traces 2*TB_DEPTH steps, emits TB_DEPTH bits
module traceback_unit
  import traceback_unit_pkg::*;
#(
  parameter int unsigned TB_DEPTH  = TB_DEPTH_DEF,
  parameter int unsigned MEM_DEPTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [NUM_STATES-1:0] dec_bits,
  input  logic [STATE_W-1:0]    best_state,
  output logic                  word_valid,
  output logic [TB_DEPTH-1:0]   word_data,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned FW = $clog2(2 * TB_DEPTH + 1);
  localparam int unsigned SW = $clog2(TB_DEPTH);
  localparam int unsigned KW = $clog2(2 * TB_DEPTH);

  localparam logic [FW-1:0] FILL_MAX  = FW'(2 * TB_DEPTH);
  localparam logic [FW-1:0] FILL_LAST = FW'(2 * TB_DEPTH - 1);
  localparam logic [SW-1:0] SEG_LAST  = SW'(TB_DEPTH - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(2 * TB_DEPTH - 1);
  localparam logic [KW-1:0] K_FIRST_OUT = KW'(TB_DEPTH);

  // Write side
  logic [AW-1:0] wr_ptr_q;
  logic [FW-1:0] fill_cnt_q;
  logic [SW-1:0] seg_cnt_q;

  // Traceback side
  tb_fsm_e                state_q, state_d;
  logic [AW-1:0]          tb_ptr_q;
  logic [STATE_W-1:0]     tb_state_q;
  logic [KW-1:0]          k_q;
  logic [TB_DEPTH-1:0]    word_acc_q;
  logic [TB_DEPTH-1:0]    word_data_q;
  logic                   word_valid_q;

  logic                   seg_wrap;
  logic                   fill_hit;
  logic                   trig_cond;
  logic                   accept;
  logic                   trigger;
  logic                   trace_en;
  logic                   emit_en;
  logic                   load_trace;
  logic [NUM_STATES-1:0]  rd_word;
  logic                   rd_bit;

  // A step triggers when it completes a segment and enough history exists
  // behind it for the merge depth. The first trigger is the step that brings
  // fill_cnt to 2*TB_DEPTH, which always coincides with a segment wrap.
  assign seg_wrap  = (seg_cnt_q == SEG_LAST);
  assign fill_hit  = (fill_cnt_q >= FILL_LAST);
  assign trig_cond = seg_wrap && fill_hit;

  // Only a triggering step can be stalled: it must wait until the previous
  // traceback has fully finished so the trigger is never dropped.
  assign busy      = (state_q != ST_IDLE);
  assign dec_ready = !(trig_cond && busy);
  assign accept    = dec_valid && dec_ready;
  assign trigger   = accept && trig_cond;

  tb_survivor_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (dec_bits),
    .raddr_i (tb_ptr_q),
    .rdata_o (rd_word)
  );

  assign rd_bit = rd_word[tb_state_q];

  // Write pointer and the fill / segment step counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      seg_cnt_q  <= '0;
    end else if (accept) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fill_cnt_q != FILL_MAX) begin
        fill_cnt_q <= fill_cnt_q + FW'(1);
      end
      seg_cnt_q <= seg_wrap ? '0 : seg_cnt_q + SW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; EMIT can chain straight into a new trace
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (trigger) state_d = ST_TRACE;
      ST_TRACE: if (k_q == K_LAST) state_d = ST_EMIT;
      ST_EMIT:  state_d = trigger ? ST_TRACE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath enables per state
  always_comb begin
    trace_en   = 1'b0;
    emit_en    = 1'b0;
    load_trace = 1'b0;
    unique case (state_q)
      ST_IDLE:  load_trace = trigger;
      ST_TRACE: trace_en   = 1'b1;
      ST_EMIT: begin
        emit_en    = 1'b1;
        load_trace = trigger;
      end
      default: ;
    endcase
  end

  // Traceback walk: one trellis step back per cycle. The first TB_DEPTH
  // steps only converge the path; the rest are shifted in newest-first so
  // the oldest step lands in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_ptr_q   <= '0;
      tb_state_q <= '0;
      k_q        <= '0;
      word_acc_q <= '0;
    end else if (load_trace) begin
      tb_ptr_q   <= wr_ptr_q;
      tb_state_q <= best_state;
      k_q        <= '0;
    end else if (trace_en) begin
      tb_state_q <= prev_state(tb_state_q, rd_bit);
      tb_ptr_q   <= tb_ptr_q - AW'(1);
      k_q        <= k_q + KW'(1);
      if (k_q >= K_FIRST_OUT) begin
        word_acc_q <= {word_acc_q[TB_DEPTH-2:0], tb_state_q[0]};
      end
    end
  end

  // Output word register: updated once per traceback, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      word_valid_q <= emit_en;
      if (emit_en) begin
        word_data_q <= word_acc_q;
      end
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;

endmodule

// File: tb/tb_traceback_unit.sv
// tb/tb_traceback_unit.sv - self-checking bench for traceback_unit against a step-history traceback model
module tb_traceback_unit;

  localparam int TBD = 32;
  localparam int MEM = 128;

  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] dec_bits;
  logic [5:0]  best_state;
  logic        word_valid;
  logic [31:0] word_data;
  logic        busy;

  traceback_unit #(
    .TB_DEPTH  (TBD),
    .MEM_DEPTH (MEM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_bits   (dec_bits),
    .best_state (best_state),
    .word_valid (word_valid),
    .word_data  (word_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // accepted step history (model input) and observed output words
  logic [63:0] m_bits[$];
  logic [5:0]  m_best[$];
  logic [31:0] got_word[$];
  int          got_cyc[$];
  int          wv_long = 0;
  logic        wv_prev = 1'b0;

  int last_acc_cyc = 0;
  int block_at = -1;
  int release_cyc = -1;
  bit blocked = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_valid) begin
      if (wv_prev) wv_long++;
      else begin
        got_word.push_back(word_data);
        got_cyc.push_back(cyc);
      end
    end
    wv_prev = word_valid;
  end

  // Trace back 64 steps from step t along the survivor history; the last 32 give the word
  function automatic logic [31:0] model_word(int t);
    logic [5:0]  s;
    logic [31:0] w;
    s = m_best[t];
    w = '0;
    for (int j = 0; j < 2 * TBD; j++) begin
      if (j >= TBD) w[2 * TBD - 1 - j] = s[0];
      s = {m_bits[t - j][s], s[5:1]};
    end
    return w;
  endfunction

  function automatic word_q_t model_words();
    word_q_t r;
    for (int t = 2 * TBD - 1; t < m_bits.size(); t += TBD) r.push_back(model_word(t));
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    dec_valid = 1'b0;
    dec_bits = '0;
    best_state = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_bits.delete();
    m_best.delete();
    got_word.delete();
    got_cyc.delete();
    wv_long = 0;
    block_at = -1;
    release_cyc = -1;
    blocked = 0;
    rst_n = 1'b1;
  endtask

  // Offer one step, keeping dec_valid high until it is accepted
  task automatic send_step(input logic [63:0] bits, input logic [5:0] best);
    int waited;
    bit done;
    waited = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      dec_valid = 1'b1;
      dec_bits = bits;
      best_state = best;
      #1;
      if (dec_ready) begin
        done = 1;
        m_bits.push_back(bits);
        m_best.push_back(best);
        last_acc_cyc = cyc + 1;
        if (blocked && release_cyc < 0) release_cyc = cyc;
        blocked = 0;
      end else begin
        if (!blocked && block_at < 0) block_at = m_bits.size();
        blocked = 1;
        waited++;
        if (waited > 300) begin
          checks++;
          errors++;
          $display("FAIL step_accept stalled: dec_ready=%0b required 1 within 300 cycles", dec_ready);
          done = 1;
        end
      end
    end
  endtask

  task automatic drain(input int n_words, input int budget);
    int c;
    c = 0;
    @(negedge clk);
    dec_valid = 1'b0;
    while ((got_word.size() < n_words || busy) && c < budget) begin
      @(negedge clk);
      #2;
      c++;
    end
    if (c >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout words=%0d busy=%0b required words=%0d busy=0", got_word.size(), busy, n_words);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dec_valid = 1'b0;
    dec_bits = '0;
    best_state = '0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", dec_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %0b want 0", word_valid); end
    checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", word_data); end
    do_reset();
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 63; i++) send_step(64'h0, 6'd0);
    @(negedge clk);
    dec_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_early_busy got %0b want 0", busy); end
    send_step(64'h0, 6'd0);
    @(negedge clk);
    dec_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_trace_busy got %0b want 1", busy); end
    drain(1, 150);
    checks++; if (got_word.size() != 1) begin errors++; $display("FAIL zero_count got %0d want 1", got_word.size()); end
    if (got_word.size() > 0) begin
      checks++; if (got_word[0] !== 32'h0) begin errors++; $display("FAIL zero_word got %h want 0", got_word[0]); end
      checks++; if (got_cyc[0] != last_acc_cyc + 2 * TBD + 1) begin
        errors++; $display("FAIL zero_latency got %0d want %0d", got_cyc[0] - last_acc_cyc, 2 * TBD + 1);
      end
    end
    checks++; if (wv_long != 0) begin errors++; $display("FAIL zero_pulse_width extra_high=%0d want 0", wv_long); end
  endtask

  task automatic test_known_message();
    logic [95:0] msg;
    logic [15:0] lfsr;
    logic [5:0]  s, ns;
    logic [63:0] bits;
    lfsr = 16'hACE1;
    for (int i = 0; i < 96; i++) begin
      msg[i] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    do_reset();
    s = 6'd0;
    for (int i = 0; i < 96; i++) begin
      ns = {s[4:0], msg[i]};
      bits = {$urandom, $urandom};
      bits[ns] = s[5];
      send_step(bits, ns);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        dec_valid = 1'b0;
      end
      s = ns;
    end
    drain(2, 300);
    checks++; if (got_word.size() != 2) begin errors++; $display("FAIL msg_count got %0d want 2", got_word.size()); end
    if (got_word.size() >= 2) begin
      checks++; if (got_word[0] !== msg[31:0]) begin errors++; $display("FAIL msg_word0 got %h want %h", got_word[0], msg[31:0]); end
      checks++; if (got_word[1] !== msg[63:32]) begin errors++; $display("FAIL msg_word1 got %h want %h", got_word[1], msg[63:32]); end
    end
  endtask

  task automatic test_backpressure();
    word_q_t exp;
    logic [31:0] g;
    do_reset();
    for (int i = 0; i < 128; i++) send_step({$urandom, $urandom}, 6'($urandom_range(0, 63)));
    drain(3, 300);
    checks++; if (block_at != 95) begin errors++; $display("FAIL bp_first_stall accepted_before=%0d want 95", block_at); end
    if (got_cyc.size() > 0) begin
      checks++; if (release_cyc != got_cyc[0]) begin
        errors++; $display("FAIL bp_release cycle=%0d want %0d", release_cyc, got_cyc[0]);
      end
    end
    exp = model_words();
    checks++; if (got_word.size() != exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_word.size(), exp.size()); end
    foreach (exp[i]) begin
      g = (i < got_word.size()) ? got_word[i] : 32'hx;
      checks++; if (g !== exp[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, g, exp[i]); end
    end
  endtask

  task automatic test_all_ones();
    do_reset();
    for (int i = 0; i < 96; i++) send_step({64{1'b1}}, 6'h3F);
    drain(2, 300);
    checks++; if (got_word.size() != 2) begin errors++; $display("FAIL ones_count got %0d want 2", got_word.size()); end
    foreach (got_word[i]) begin
      checks++; if (got_word[i] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ones_word%0d got %h want ffffffff", i, got_word[i]); end
    end
  endtask

  task automatic test_reset_mid_trace();
    word_q_t exp;
    do_reset();
    for (int i = 0; i < 64; i++) send_step({$urandom, $urandom}, 6'($urandom_range(0, 63)));
    @(negedge clk);
    dec_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL midrst_wvalid got %0b want 0", word_valid); end
    do_reset();
    repeat (80) @(negedge clk);
    checks++; if (got_word.size() != 0) begin errors++; $display("FAIL midrst_no_word got %0d want 0", got_word.size()); end
    for (int i = 0; i < 64; i++) send_step({$urandom, $urandom}, 6'($urandom_range(0, 63)));
    drain(1, 200);
    exp = model_words();
    checks++; if (got_word.size() != 1) begin errors++; $display("FAIL midrst_count got %0d want 1", got_word.size()); end
    if (got_word.size() > 0) begin
      checks++; if (got_word[0] !== exp[0]) begin errors++; $display("FAIL midrst_word got %h want %h", got_word[0], exp[0]); end
    end
  endtask

  task automatic test_pointer_wrap();
    word_q_t exp;
    logic [31:0] g;
    do_reset();
    for (int i = 0; i < 300; i++) send_step({$urandom, $urandom}, 6'($urandom_range(0, 63)));
    drain(8, 400);
    exp = model_words();
    checks++; if (exp.size() != 8 || got_word.size() != 8) begin
      errors++; $display("FAIL wrap_count got %0d want 8", got_word.size());
    end
    foreach (exp[i]) begin
      g = (i < got_word.size()) ? got_word[i] : 32'hx;
      checks++; if (g !== exp[i]) begin errors++; $display("FAIL wrap_word%0d got %h want %h", i, g, exp[i]); end
    end
    checks++; if (wv_long != 0) begin errors++; $display("FAIL wrap_pulse_width extra_high=%0d want 0", wv_long); end
  endtask

  initial begin
    rst_n = 1'b0;
    dec_valid = 1'b0;
    dec_bits = '0;
    best_state = '0;
    test_reset();
    test_all_zero();
    test_known_message();
    test_backpressure();
    test_all_ones();
    test_reset_mid_trace();
    test_pointer_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
